// File: rtl/belief_normalizer_pkg.sv
// Shared types and constants for the belief normaliser: Q2.14 constants,
// data width, the controller state encoding and an input clamp helper.
package belief_normalizer_pkg;

    localparam int DATA_W = 16;

    // Q2.14 unity and the largest positive Q2.14 value.
    localparam logic [DATA_W-1:0] ONE  = 16'd16384;
    localparam logic [DATA_W-1:0] QMAX = 16'd32767;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_SCALE  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_BYPASS = 3'd4,
        ST_EMIT   = 3'd5
    } state_t;

    // Negative similarities carry no belief mass; clamp them to zero.
    function automatic logic [DATA_W-1:0] clamp_nonneg(input logic signed [DATA_W-1:0] x);
        return x[DATA_W-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/belief_normalizer_if.sv
// Bundles the input stream, output stream, divider link and status of the
// belief normaliser.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both high; a producer holding valid keeps its
// data (and last) stable until that transfer, and never retracts valid.
// The divider link is a one-cycle div_en start pulse answered later by a
// one-cycle div_flag pulse carrying div_quotient.
interface belief_normalizer_if;
    import belief_normalizer_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_last;

    logic                     div_en;
    logic signed [DATA_W-1:0] div_dividend;
    logic signed [DATA_W-1:0] div_division;
    logic signed [DATA_W-1:0] div_quotient;
    logic                     div_flag;

    logic                     busy;
    logic                     err;
    state_t                   dbg_state;

    // Normaliser side.
    modport slave (
        input  in_valid, in_data, out_ready, div_quotient, div_flag,
        output in_ready, out_valid, out_data, out_last,
               div_en, div_dividend, div_division, busy, err, dbg_state
    );

    // Environment side: upstream source, downstream sink and divider.
    modport master (
        output in_valid, in_data, out_ready, div_quotient, div_flag,
        input  in_ready, out_valid, out_data, out_last,
               div_en, div_dividend, div_division, busy, err, dbg_state
    );

endinterface

// File: rtl/belief_normalizer_frame_buf.sv
// N x 16 frame buffer. Write pointer cnt fills the frame in arrival order;
// read pointer idx walks it during normalisation. rd_peek shows the element
// idx will point at after this edge, so the controller can decide the next
// element's path in the same cycle it advances.
module norm_frame_buf
    import belief_normalizer_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_home,
    input  logic              rd_adv,
    input  logic              clr,
    output logic [IDX_W-1:0]  cnt,
    output logic [IDX_W-1:0]  idx,
    output logic              last_wr,
    output logic              last_rd,
    output logic [DATA_W-1:0] rd_peek
);

    logic [DATA_W-1:0] mem [N];
    logic [IDX_W-1:0]  idx_nxt;

    // Next read pointer: frame clear or rewind wins over advance.
    always_comb begin
        idx_nxt = idx;
        if (clr || rd_home) begin
            idx_nxt = '0;
        end else if (rd_adv) begin
            idx_nxt = idx + 1'b1;
        end
    end

    assign rd_peek = mem[idx_nxt];
    assign last_wr = (cnt == IDX_W'(N - 1));
    assign last_rd = (idx == IDX_W'(N - 1));

    // Storage and pointers; reset discards the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clr) begin
                cnt <= '0;
            end else if (wr_en) begin
                mem[cnt] <= wr_data;
                cnt      <= cnt + 1'b1;
            end
            idx <= idx_nxt;
        end
    end

endmodule

// File: rtl/belief_normalizer.sv
// Belief normaliser: gathers N clamped Q2.14 values, scales the frame sum
// into the divider's range and emits element/sum quotients in input order
// through an external divider. Elements that are zero, or frames whose sum
// is zero, skip the divider.
module belief_normalizer
    import belief_normalizer_pkg::*;
#(
    parameter int N           = 8,
    parameter int DIV_TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    belief_normalizer_if.slave bus
);

    localparam int LOG_N = $clog2(N);
    localparam int ACC_W = DATA_W + LOG_N;
    localparam int K_W   = $clog2(LOG_N + 1);
    localparam int T_W   = $clog2(DIV_TIMEOUT + 1);

    localparam logic [DATA_W-1:0] UNIFORM = ONE >> LOG_N;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [K_W-1:0]    k;
    logic [T_W-1:0]    tmo_cnt;
    logic              out_valid_q;
    logic              out_last_q;
    logic [DATA_W-1:0] out_data_q;
    logic              div_en_q;
    logic [DATA_W-1:0] div_dividend_q;
    logic [DATA_W-1:0] div_division_q;
    logic              err_q;

    logic              accept;
    logic              emit_fire;
    logic              scale_done;
    logic [DATA_W-1:0] in_clamped;
    logic [LOG_N-1:0]  cnt;
    logic [LOG_N-1:0]  idx;
    logic              last_wr;
    logic              last_rd;
    logic [DATA_W-1:0] rd_peek;
    logic [DATA_W-1:0] elem;
    logic              dec_bypass;
    logic [DATA_W-1:0] dec_data;

    assign accept     = (state == ST_LOAD) && bus.in_valid;
    assign emit_fire  = (state == ST_EMIT) && out_valid_q && bus.out_ready;
    assign scale_done = (state == ST_SCALE) && (acc <= ACC_W'(QMAX));
    assign in_clamped = clamp_nonneg(bus.in_data);

    norm_frame_buf #(.N(N), .IDX_W(LOG_N)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data (in_clamped),
        .rd_home (scale_done),
        .rd_adv  (emit_fire && !last_rd),
        .clr     (emit_fire && last_rd),
        .cnt     (cnt),
        .idx     (idx),
        .last_wr (last_wr),
        .last_rd (last_rd),
        .rd_peek (rd_peek)
    );

    // Per-element path: a zero sum means a uniform belief; a zero element
    // needs no division; anything else goes to the divider.
    always_comb begin
        elem       = rd_peek >> k;
        dec_bypass = 1'b0;
        dec_data   = '0;
        if (acc == '0) begin
            dec_bypass = 1'b1;
            dec_data   = UNIFORM;
        end else if (elem == '0) begin
            dec_bypass = 1'b1;
        end
    end

    // Controller: frame collection, sum scaling, divider sequencing, emit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_LOAD;
            acc            <= '0;
            k              <= '0;
            tmo_cnt        <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_data_q     <= '0;
            div_en_q       <= 1'b0;
            div_dividend_q <= '0;
            div_division_q <= '0;
            err_q          <= 1'b0;
        end else begin
            div_en_q <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        acc <= acc + ACC_W'(in_clamped);
                        if (last_wr) begin
                            state <= ST_SCALE;
                            k     <= '0;
                        end
                    end
                end
                ST_SCALE: begin
                    if (!scale_done) begin
                        acc <= acc >> 1;
                        k   <= k + 1'b1;
                    end else if (dec_bypass) begin
                        state      <= ST_BYPASS;
                        out_data_q <= dec_data;
                    end else begin
                        state          <= ST_ISSUE;
                        div_en_q       <= 1'b1;
                        div_dividend_q <= elem;
                        div_division_q <= acc[DATA_W-1:0];
                    end
                end
                ST_ISSUE: begin
                    state   <= ST_WAIT;
                    tmo_cnt <= '0;
                end
                ST_WAIT: begin
                    if (bus.div_flag) begin
                        state       <= ST_EMIT;
                        out_data_q  <= bus.div_quotient;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_rd;
                    end else if (tmo_cnt == T_W'(DIV_TIMEOUT - 1)) begin
                        state       <= ST_EMIT;
                        out_data_q  <= '0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_rd;
                        err_q       <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_BYPASS: begin
                    state       <= ST_EMIT;
                    out_valid_q <= 1'b1;
                    out_last_q  <= last_rd;
                end
                ST_EMIT: begin
                    if (emit_fire) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (last_rd) begin
                            state <= ST_LOAD;
                            acc   <= '0;
                            k     <= '0;
                        end else if (dec_bypass) begin
                            state      <= ST_BYPASS;
                            out_data_q <= dec_data;
                        end else begin
                            state          <= ST_ISSUE;
                            div_en_q       <= 1'b1;
                            div_dividend_q <= elem;
                            div_division_q <= acc[DATA_W-1:0];
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    assign bus.in_ready     = (state == ST_LOAD);
    assign bus.busy         = (state != ST_LOAD);
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_data     = out_data_q;
    assign bus.div_en       = div_en_q;
    assign bus.div_dividend = div_dividend_q;
    assign bus.div_division = div_division_q;
    assign bus.err          = err_q;
    assign bus.dbg_state    = state;

endmodule
